// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the program-RAM port arbiter.
// Requester ids double as read-return tags in the arbiter pipeline.
package ram_arb_pkg;

  localparam int unsigned DEF_ADDR_W    = 4;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_CPU_BURST = 4;
  // Wide enough for CPU_BURST up to 15.
  localparam int unsigned BURST_W       = 4;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_CPU,
    REQ_DBG,
    REQ_LD
  } req_id_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOCK_PEND,
    ST_LOCKED
  } arb_state_t;

  function automatic logic is_read(req_id_t id);
    return (id == REQ_CPU) || (id == REQ_DBG);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_port_arbiter.
// master = requesters plus RAM model, slave = the arbiter itself.
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_lock;
  logic              ld_locked;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, dbg_req, dbg_addr,
    output ld_req, ld_addr, ld_wdata, ld_lock, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ld_gnt, ld_locked, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_addr, dbg_req, dbg_addr,
    input  ld_req, ld_addr, ld_wdata, ld_lock, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
    output ld_gnt, ld_locked, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; req[0] is debug, req[1] is loader.
// The pointer names the side that wins a tie and moves only when en takes a grant.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  req_id_t ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (ptr_q == REQ_LD) begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end else begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= REQ_DBG;
    end else if (en) begin
      if (gnt[0])      ptr_q <= REQ_LD;
      else if (gnt[1]) ptr_q <= REQ_DBG;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port program RAM arbiter: CPU fetch has priority with a burst cap, debug and
// loader share round-robin, and a loader lock drains reads before granting exclusivity.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned CPU_BURST = DEF_CPU_BURST
) (
  input logic                clk,
  input logic                rst,
  ram_port_arbiter_if.slave  bus
);

  arb_state_t        state_q;
  logic              ld_locked_q;

  logic              cpu_gnt_q, dbg_gnt_q, ld_gnt_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  // tag0 tracks the address now on the RAM bus, tag1 the data now on mem_rdata.
  req_id_t           tag0_q, tag1_q;

  logic              excl;
  logic              other_pend;
  logic              burst_full;
  logic              cpu_win;
  logic [1:0]        rr_req, rr_gnt;
  req_id_t           gnt_id;

  // Loader lock blocks new reads from the very edge it is seen.
  assign excl       = bus.ld_lock;
  assign other_pend = bus.dbg_req | bus.ld_req;
  assign burst_full = burst_q >= BURST_W'(CPU_BURST);
  assign cpu_win    = !excl && bus.cpu_req && !(other_pend && burst_full);
  assign rr_req     = excl ? {bus.ld_req, 1'b0} : {bus.ld_req, bus.dbg_req};

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req (rr_req),
    .en  (!cpu_win),
    .gnt (rr_gnt)
  );

  always_comb begin
    gnt_id = REQ_NONE;
    if (cpu_win)        gnt_id = REQ_CPU;
    else if (rr_gnt[0]) gnt_id = REQ_DBG;
    else if (rr_gnt[1]) gnt_id = REQ_LD;
  end

  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (gnt_id)
      REQ_CPU:  mem_addr_d = bus.cpu_addr;
      REQ_DBG:  mem_addr_d = bus.dbg_addr;
      REQ_LD: begin
        mem_addr_d  = bus.ld_addr;
        mem_wdata_d = bus.ld_wdata;
      end
      default: ;
    endcase
  end

  // Counts CPU wins only while someone else waits; any other outcome clears it.
  always_comb begin
    burst_d = '0;
    if ((gnt_id == REQ_CPU) && other_pend) burst_d = burst_q + BURST_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_gnt_q   <= 1'b0;
      dbg_gnt_q   <= 1'b0;
      ld_gnt_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      burst_q     <= '0;
      tag0_q      <= REQ_NONE;
      tag1_q      <= REQ_NONE;
    end else begin
      cpu_gnt_q   <= (gnt_id == REQ_CPU);
      dbg_gnt_q   <= (gnt_id == REQ_DBG);
      ld_gnt_q    <= (gnt_id == REQ_LD);
      mem_we_q    <= (gnt_id == REQ_LD);
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      burst_q     <= burst_d;
      tag0_q      <= is_read(gnt_id) ? gnt_id : REQ_NONE;
      tag1_q      <= tag0_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ld_locked_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (bus.ld_lock) state_q <= ST_LOCK_PEND;
        end
        ST_LOCK_PEND: begin
          if (!bus.ld_lock) begin
            state_q <= ST_RUN;
          end else if ((tag0_q == REQ_NONE) && (tag1_q == REQ_NONE)) begin
            state_q     <= ST_LOCKED;
            ld_locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (!bus.ld_lock) begin
            state_q     <= ST_RUN;
            ld_locked_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_RUN;
          ld_locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.dbg_gnt    = dbg_gnt_q;
  assign bus.ld_gnt     = ld_gnt_q;
  assign bus.ld_locked  = ld_locked_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.cpu_rvalid = (tag1_q == REQ_CPU);
  assign bus.dbg_rvalid = (tag1_q == REQ_DBG);
  // RAM output is already registered; route it only to the requester that owns it.
  assign bus.cpu_rdata  = (tag1_q == REQ_CPU) ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = (tag1_q == REQ_DBG) ? bus.mem_rdata : '0;

endmodule
